dff_checker: RTL and testbench

Synthesizable response checker for the single-bit D flip-flop with synchronous reset. It observes the flip-flop's d, reset, q and qb each clock and predicts q one cycle ahead. It flags data and complement mismatches and keeps saturating check and error counts. It sits beside the flip-flop under test in simulation and on-chip self-test builds, and lets the flip-flop bench self-check instead of relying on waveform inspection.

---
 rtl/dff_checker.sv | 115 +++++++++++
 tb/tb_dff_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dff_checker.sv
// dff_checker: response checker for a single-bit D flip-flop with synchronous reset.
// Predicts q one cycle ahead from the observed d/reset and compares it against the
// observed q/qb. Reports registered error flags, an error strobe, a sticky flag and
// saturating check/error counters.
module dff_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             d_obs,
    input  logic             dut_rst_obs,
    input  logic             q_obs,
    input  logic             qb_obs,
    output logic             err_pulse,
    output logic             err_data,
    output logic             err_comp,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter increment that sticks at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic exp;
    logic data_mis;
    logic comp_mis;
    logic any_mis;

    // Mismatch detection; case inequality so X/Z on q_obs or qb_obs counts as an error.
    always_comb begin
        data_mis = (q_obs !== exp);
        comp_mis = (qb_obs !== ~q_obs);
        any_mis  = data_mis | comp_mis;
    end

    // Prediction of q for the next edge, tracked every cycle regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp <= 1'b0;
        end else begin
            exp <= dut_rst_obs ? 1'b0 : d_obs;
        end
    end

    // Checker FSM, error flags and saturating counters; clr dominates everything but rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            err_pulse  <= 1'b0;
            err_data   <= 1'b0;
            err_comp   <= 1'b0;
            err_sticky <= 1'b0;
            chk_count  <= '0;
            err_count  <= '0;
        end else if (clr) begin
            state      <= IDLE;
            err_pulse  <= 1'b0;
            err_data   <= 1'b0;
            err_comp   <= 1'b0;
            err_sticky <= 1'b0;
            chk_count  <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    err_pulse <= 1'b0;
                    err_data  <= 1'b0;
                    err_comp  <= 1'b0;
                    if (en) state <= ARM;
                end
                ARM: begin
                    // Prediction is loading this cycle, nothing to compare yet.
                    err_pulse <= 1'b0;
                    err_data  <= 1'b0;
                    err_comp  <= 1'b0;
                    state     <= en ? CHECK : IDLE;
                end
                CHECK: begin
                    chk_count <= sat_inc(chk_count);
                    err_data  <= data_mis;
                    err_comp  <= comp_mis;
                    err_pulse <= any_mis;
                    if (any_mis) begin
                        err_count  <= sat_inc(err_count);
                        err_sticky <= 1'b1;
                    end
                    if (any_mis && STOP_ON_ERR) begin
                        state <= FAULT;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    // FAULT: everything frozen except the strobe; only clr or rst leaves.
                    err_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_checker.sv
// Directed bench for dff_checker: a behavioural flip-flop feeds three checker
// instances (CNT_W=8/STOP=0, CNT_W=8/STOP=1, CNT_W=2/STOP=0) with fault injection.
module tb_dff_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic d = 1'b0;
    logic ff_rst = 1'b0;
    logic ff_q = 1'b0;
    logic [1:0] q_mode = 2'd0;   // 0 normal, 1 inverted, 2 stuck at 1
    logic qb_mode = 1'b0;        // 0 normal, 1 qb equals q
    logic q_obs, qb_obs;

    int tests = 0;
    int failed = 0;

    logic       a_pulse, a_data, a_comp, a_sticky;
    logic [7:0] a_chk, a_err;
    logic [1:0] a_state;
    logic       b_pulse, b_data, b_comp, b_sticky;
    logic [7:0] b_chk, b_err;
    logic [1:0] b_state;
    logic       c_pulse, c_data, c_comp, c_sticky;
    logic [1:0] c_chk, c_err;
    logic [1:0] c_state;

    always #5 clk = ~clk;

    // Flip-flop under observation: synchronous reset D flip-flop.
    always @(posedge clk) ff_q <= ff_rst ? 1'b0 : d;

    assign q_obs  = (q_mode == 2'd0) ? ff_q : (q_mode == 2'd1) ? ~ff_q : 1'b1;
    assign qb_obs = qb_mode ? q_obs : ~ff_q;

    dff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d_obs(d), .dut_rst_obs(ff_rst),
        .q_obs(q_obs), .qb_obs(qb_obs), .err_pulse(a_pulse), .err_data(a_data),
        .err_comp(a_comp), .err_sticky(a_sticky), .chk_count(a_chk), .err_count(a_err),
        .state(a_state));

    dff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d_obs(d), .dut_rst_obs(ff_rst),
        .q_obs(q_obs), .qb_obs(qb_obs), .err_pulse(b_pulse), .err_data(b_data),
        .err_comp(b_comp), .err_sticky(b_sticky), .chk_count(b_chk), .err_count(b_err),
        .state(b_state));

    dff_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d_obs(d), .dut_rst_obs(ff_rst),
        .q_obs(q_obs), .qb_obs(qb_obs), .err_pulse(c_pulse), .err_data(c_data),
        .err_comp(c_comp), .err_sticky(c_sticky), .chk_count(c_chk), .err_count(c_err),
        .state(c_state));

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++; if (a_state !== 2'd0) begin failed++; $display("FAIL reset_state got %0d want 0", a_state); end
        tests++; if ({a_pulse, a_data, a_comp, a_sticky} !== 4'b0000) begin failed++; $display("FAIL reset_flags got %b want 0000", {a_pulse, a_data, a_comp, a_sticky}); end
        tests++; if (a_chk !== 8'd0 || a_err !== 8'd0) begin failed++; $display("FAIL reset_counts got %0d/%0d want 0/0", a_chk, a_err); end
    endtask

    task automatic test_clean_run();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            d = ~d;
        end
        tests++; if (a_chk !== 8'd18) begin failed++; $display("FAIL clean_chk_count got %0d want 18", a_chk); end
        tests++; if (a_err !== 8'd0) begin failed++; $display("FAIL clean_err_count got %0d want 0", a_err); end
        tests++; if (a_sticky !== 1'b0) begin failed++; $display("FAIL clean_sticky got %b want 0", a_sticky); end
        tests++; if (a_state !== 2'd2) begin failed++; $display("FAIL clean_state got %0d want 2", a_state); end
    endtask

    task automatic test_data_fault();
        q_mode = 2'd1;
        step();
        tests++; if ({a_pulse, a_data, a_comp} !== 3'b111) begin failed++; $display("FAIL dfault_flags got %b want 111", {a_pulse, a_data, a_comp}); end
        tests++; if (a_err !== 8'd1 || a_sticky !== 1'b1) begin failed++; $display("FAIL dfault_err got %0d sticky %b want 1 sticky 1", a_err, a_sticky); end
        tests++; if (b_state !== 2'd3) begin failed++; $display("FAIL dfault_stop_state got %0d want 3", b_state); end
        q_mode = 2'd0;
        step();
        tests++; if ({a_pulse, a_data, a_comp} !== 3'b000) begin failed++; $display("FAIL drecover_flags got %b want 000", {a_pulse, a_data, a_comp}); end
        tests++; if (a_sticky !== 1'b1 || a_err !== 8'd1) begin failed++; $display("FAIL drecover_sticky got %b err %0d want 1 err 1", a_sticky, a_err); end
        tests++; if (a_chk !== 8'd20) begin failed++; $display("FAIL drecover_chk got %0d want 20", a_chk); end
    endtask

    task automatic test_comp_fault();
        clr = 1'b1;
        step();
        clr = 1'b0;
        tests++; if (a_state !== 2'd0 || b_state !== 2'd0) begin failed++; $display("FAIL clr_state got %0d/%0d want 0/0", a_state, b_state); end
        tests++; if (a_chk !== 8'd0 || a_err !== 8'd0 || a_sticky !== 1'b0) begin failed++; $display("FAIL clr_counts got %0d/%0d/%b want 0/0/0", a_chk, a_err, a_sticky); end
        step();
        tests++; if (a_state !== 2'd1) begin failed++; $display("FAIL arm_state got %0d want 1", a_state); end
        step();
        tests++; if (a_state !== 2'd2 || a_chk !== 8'd0) begin failed++; $display("FAIL check_entry got state %0d chk %0d want 2/0", a_state, a_chk); end
        qb_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if ({a_pulse, a_data, a_comp} !== 3'b101) begin failed++; $display("FAIL cfault_flags[%0d] got %b want 101", i, {a_pulse, a_data, a_comp}); end
            tests++; if (b_state !== 2'd3 || b_err !== 8'd1) begin failed++; $display("FAIL cfault_stop[%0d] got state %0d err %0d want 3/1", i, b_state, b_err); end
        end
        tests++; if (a_err !== 8'd3) begin failed++; $display("FAIL cfault_err_count got %0d want 3", a_err); end
        tests++; if (b_chk !== 8'd1 || b_sticky !== 1'b1 || b_comp !== 1'b1) begin failed++; $display("FAIL fault_frozen got chk %0d sticky %b comp %b want 1/1/1", b_chk, b_sticky, b_comp); end
        qb_mode = 1'b0;
        step();
        tests++; if (a_pulse !== 1'b0 || b_state !== 2'd3) begin failed++; $display("FAIL crecover got pulse %b bstate %0d want 0/3", a_pulse, b_state); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        tests++; if (b_state !== 2'd0 || b_err !== 8'd0 || b_chk !== 8'd0 || b_sticky !== 1'b0) begin failed++; $display("FAIL fault_clr got %0d/%0d/%0d/%b want 0/0/0/0", b_state, b_err, b_chk, b_sticky); end
    endtask

    task automatic test_dut_reset();
        step();
        step();
        ff_rst = 1'b1;
        d = 1'b1;
        step();
        ff_rst = 1'b0;
        d = 1'b0;
        step();
        tests++; if (a_err !== 8'd0 || a_chk !== 8'd2) begin failed++; $display("FAIL dutrst_ok got err %0d chk %0d want 0/2", a_err, a_chk); end
        ff_rst = 1'b1;
        d = 1'b1;
        step();
        ff_rst = 1'b0;
        d = 1'b0;
        q_mode = 2'd2;
        step();
        tests++; if (a_data !== 1'b1 || a_pulse !== 1'b1 || a_err !== 8'd1) begin failed++; $display("FAIL dutrst_stuck got data %b pulse %b err %0d want 1/1/1", a_data, a_pulse, a_err); end
        q_mode = 2'd0;
    endtask

    task automatic test_en_drop();
        q_mode = 2'd1;
        en = 1'b0;
        step();
        tests++; if (a_pulse !== 1'b1 || a_chk !== 8'd5 || a_state !== 2'd0) begin failed++; $display("FAIL en_drop got pulse %b chk %0d state %0d want 1/5/0", a_pulse, a_chk, a_state); end
        q_mode = 2'd0;
        step();
        tests++; if (a_state !== 2'd0 || a_chk !== 8'd5) begin failed++; $display("FAIL en_idle got state %0d chk %0d want 0/5", a_state, a_chk); end
        en = 1'b1;
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        step();
        q_mode = 2'd1;
        repeat (6) step();
        tests++; if (c_err !== 2'd3 || c_chk !== 2'd3) begin failed++; $display("FAIL sat_counts got %0d/%0d want 3/3", c_err, c_chk); end
        tests++; if (c_sticky !== 1'b1 || c_state !== 2'd2) begin failed++; $display("FAIL sat_sticky got %b state %0d want 1/2", c_sticky, c_state); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({c_pulse, c_data, c_comp, c_sticky, c_chk, c_err, c_state} !== 10'd0) begin failed++; $display("FAIL async_rst_c got %b want 0", {c_pulse, c_data, c_comp, c_sticky, c_chk, c_err, c_state}); end
        tests++; if ({a_pulse, a_sticky, a_chk, a_err, a_state} !== 20'd0) begin failed++; $display("FAIL async_rst_a got %b want 0", {a_pulse, a_sticky, a_chk, a_err, a_state}); end
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        q_mode = 2'd0;
        step();
        step();
        tests++; if (c_state !== 2'd0) begin failed++; $display("FAIL post_rst_idle got %0d want 0", c_state); end
        en = 1'b1;
        step();
        tests++; if (c_state !== 2'd1) begin failed++; $display("FAIL post_rst_arm got %0d want 1", c_state); end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_data_fault();
        test_comp_fault();
        test_dut_reset();
        test_en_drop();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
